// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu -- data memory and load/store unit for a single-cycle core.
//
// Sits directly on the core's memory port. It performs little-endian byte-lane
// stores, load extraction with sign or zero extension, misaligned-access
// trapping, and exposes a small word-only MMIO status window.
//
// Ports:
//   clk           core clock, all state updates on the rising edge
//   reset         asynchronous, active-high reset
//   mem_we        store strobe (core MemWrite)
//   addr          byte address (ALU result)
//   wr_data       store data (rs2)
//   funct3        access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   rd_data       combinational load result (valid whenever mem_we = 0)
//   misalign_flag sticky misaligned-access flag
//
// Parameters:
//   ADDR_WIDTH    word-address bits; the RAM holds 2**ADDR_WIDTH 32-bit words
//   MMIO_HI       value of addr[31:16] that selects the MMIO window
//
// Build option:
//   DMEM_CYCLE_COUNTER_EN  when defined, MMIO offset 0x8 is a free-running
//                          32-bit CYCLE counter that a word store can load.
//                          When undefined, offset 0x8 reads 0 and no counter
//                          flops exist.
//
// MMIO map (word accesses only; other sizes read 0 and are ignored):
//   0x0 STATUS     bit0 = misalign_flag; any write clears flag and FAULT_ADDR
//   0x4 FAULT_ADDR address of the first misaligned access, read-only
//   0x8 CYCLE      optional cycle counter
// -----------------------------------------------------------------------------
module dmem_lsu #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [15:0] MMIO_HI    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_we,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [2:0]  funct3,
  output logic [31:0] rd_data,
  output logic        misalign_flag
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [15:0] OFF_STATUS = 16'h0000;
  localparam logic [15:0] OFF_FAULT  = 16'h0004;
  localparam logic [15:0] OFF_CYCLE  = 16'h0008;

  // ---------------------------------------------------------------------------
  // Storage and architectural registers
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic        flag_q,  flag_d;
  logic [31:0] fault_q, fault_d;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic                  is_mmio;
  logic                  is_byte, is_half, is_word;
  logic                  misaligned;
  logic                  mmio_word_ok;
  logic [15:0]           mmio_off;
  logic [ADDR_WIDTH-1:0] ram_idx;

  assign is_mmio  = (addr[31:16] == MMIO_HI);
  assign mmio_off = addr[15:0];
  assign ram_idx  = addr[ADDR_WIDTH+1:2];

  assign is_byte  = (funct3 == F3_B) || (funct3 == F3_BU);
  assign is_half  = (funct3 == F3_H) || (funct3 == F3_HU);
  assign is_word  = (funct3 == F3_W);

  // The MMIO window only recognises word accesses, so a misaligned halfword
  // aimed at it is simply ignored rather than trapped.
  assign misaligned = (is_word && (addr[1:0] != 2'b00)) ||
                      (!is_mmio && is_half && addr[0]);

  assign mmio_word_ok = is_mmio && is_word && (addr[1:0] == 2'b00);

  // ---------------------------------------------------------------------------
  // Store path: byte enables and lane-replicated write data
  // ---------------------------------------------------------------------------
  logic [3:0]  byte_en;
  logic [31:0] lane_data;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    byte_en   = 4'b0000;
    lane_data = wr_data;
    if (is_byte) begin
      lane_data = {4{wr_data[7:0]}};
    end else if (is_half) begin
      lane_data = {2{wr_data[15:0]}};
    end
    if (mem_we && !is_mmio && !misaligned) begin
      if (is_byte) begin
        byte_en[addr[1:0]] = 1'b1;
      end else if (is_half) begin
        byte_en = addr[1] ? 4'b1100 : 4'b0011;
      end else if (is_word) begin
        byte_en = 4'b1111;
      end
    end
  end

  // NOTE: the RAM array has no reset; only the control registers below are
  // reset, so the array maps onto plain memory without a clear port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        mem_q[ram_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load path
  // ---------------------------------------------------------------------------
  logic [31:0] ram_word;
  logic [31:0] ram_shifted;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] ram_rd;
  logic [31:0] mmio_rd;
  logic [31:0] cycle_rd;

  assign ram_word    = mem_q[ram_idx];
  assign ram_shifted = ram_word >> {addr[1:0], 3'b000};
  assign byte_sel    = ram_shifted[7:0];
  assign half_sel    = addr[1] ? ram_word[31:16] : ram_word[15:0];

  always_comb begin
    ram_rd = 32'h0;
    case (funct3)
      F3_B:    ram_rd = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ram_rd = {24'h0, byte_sel};
      F3_H:    ram_rd = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ram_rd = {16'h0, half_sel};
      F3_W:    ram_rd = ram_word;
      default: ram_rd = 32'h0;
    endcase
  end

  always_comb begin
    mmio_rd = 32'h0;
    if (mmio_word_ok) begin
      case (mmio_off)
        OFF_STATUS: mmio_rd = {31'h0, flag_q};
        OFF_FAULT:  mmio_rd = fault_q;
        OFF_CYCLE:  mmio_rd = cycle_rd;
        default:    mmio_rd = 32'h0;
      endcase
    end
  end

  always_comb begin
    rd_data = 32'h0;
    if (!misaligned) begin
      rd_data = is_mmio ? mmio_rd : ram_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky fault flag and first-fault address
  // ---------------------------------------------------------------------------
  logic status_clr;

  assign status_clr = mem_we && mmio_word_ok && (mmio_off == OFF_STATUS);

  always_comb begin
    flag_d  = flag_q;
    fault_d = fault_q;
    if (status_clr) begin
      flag_d  = 1'b0;
      fault_d = 32'h0;
    end else if (misaligned) begin
      flag_d = 1'b1;
      // Only the first fault is recorded until software clears STATUS.
      if (!flag_q) begin
        fault_d = addr;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_q  <= 1'b0;
      fault_q <= 32'h0;
    end else begin
      flag_q  <= flag_d;
      fault_q <= fault_d;
    end
  end

  assign misalign_flag = flag_q;

  // ---------------------------------------------------------------------------
  // Optional cycle counter
  // ---------------------------------------------------------------------------
`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_q, cycle_d;

  // A word store to CYCLE takes priority over the increment on the same edge.
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (mem_we && mmio_word_ok && (mmio_off == OFF_CYCLE)) begin
      cycle_d = wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= 32'h0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  assign cycle_rd = cycle_q;
`else
  assign cycle_rd = 32'h0;
`endif

endmodule
